if_stage: RTL

- Instruction-fetch stage of the 5-stage MIPS pipeline. Holds the PC and drives the instruction-memory address.
- Captures the fetched word into the IF/ID pipeline register consumed by decode.
- Handles load-use stalls from the hazard unit and branch/jump redirects with IF/ID flush from EX/ID.
- Keeps fetch and stall performance counters.

---
 rtl/if_stage_if.sv | 30 +++
 rtl/if_stage.sv | 84 ++++++++
 2 files changed

// File: rtl/if_stage_if.sv
// Fetch-stage bus: hazard/redirect controls in, imem port, IF/ID register and counters out.
// master = environment (hazard unit, EX/ID, instruction memory); slave = if_stage.
interface if_stage_if #(
  parameter int unsigned IMEM_AW = 10,
  parameter int unsigned CNT_W   = 32
);
  logic               stall;
  logic               redirect;
  logic [31:0]        redirect_pc;
  logic               flush;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic [31:0]        pc;
  logic [31:0]        ifid_instr;
  logic [31:0]        ifid_pc4;
  logic               ifid_valid;
  logic               misalign_err;
  logic [CNT_W-1:0]   fetch_cnt;
  logic [CNT_W-1:0]   stall_cnt;

  modport master (
    output stall, redirect, redirect_pc, flush, imem_rdata,
    input  imem_addr, pc, ifid_instr, ifid_pc4, ifid_valid, misalign_err, fetch_cnt, stall_cnt
  );

  modport slave (
    input  stall, redirect, redirect_pc, flush, imem_rdata,
    output imem_addr, pc, ifid_instr, ifid_pc4, ifid_valid, misalign_err, fetch_cnt, stall_cnt
  );
endinterface

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC register, IF/ID pipeline register, stall/redirect/flush
// handling, sticky misaligned-redirect flag and saturating fetch/stall counters.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned IMEM_AW  = 10,
  parameter int unsigned CNT_W    = 32
) (
  input  logic      clk,
  input  logic      rst,
  if_stage_if.slave bus
);

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc4_q, pc4_d;
  logic             valid_q, valid_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [31:0]      pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  // Redirect beats stall for the PC; flush/redirect beat stall for IF/ID.
  always_comb begin
    pc_d        = pc_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    misalign_d  = misalign_q | (bus.redirect && (bus.redirect_pc[1:0] != 2'b00));
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;

    if (bus.redirect) begin
      pc_d = {bus.redirect_pc[31:2], 2'b00};
    end else if (!bus.stall) begin
      pc_d = pc_plus4;
    end

    if (bus.flush || bus.redirect) begin
      instr_d = 32'h0;
      pc4_d   = 32'h0;
      valid_d = 1'b0;
    end else if (!bus.stall) begin
      instr_d = bus.imem_rdata;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
      if (!(&fetch_cnt_q)) fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
    end

    if (bus.stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      instr_q     <= 32'h0;
      pc4_q       <= 32'h0;
      valid_q     <= 1'b0;
      misalign_q  <= 1'b0;
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
      misalign_q  <= misalign_d;
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Upper PC bits intentionally alias into the instruction memory.
  assign bus.imem_addr    = pc_q[IMEM_AW+1:2];
  assign bus.pc           = pc_q;
  assign bus.ifid_instr   = instr_q;
  assign bus.ifid_pc4     = pc4_q;
  assign bus.ifid_valid   = valid_q;
  assign bus.misalign_err = misalign_q;
  assign bus.fetch_cnt    = fetch_cnt_q;
  assign bus.stall_cnt    = stall_cnt_q;

endmodule
